// File: rtl/reg_file_read_streamer.sv
// Walks an inclusive, wrapping address range of a register file read port and
// streams {address, data} pairs out over a valid/ready handshake.
module reg_file_read_streamer #(
    parameter int N = 32,
    parameter int A = 5
) (
    input  logic         Clk,
    input  logic         R,
    input  logic         Start,
    input  logic [A-1:0] FirstAddr,
    input  logic [A-1:0] LastAddr,
    output logic [A-1:0] RdAddr,
    input  logic [N-1:0] RdData,
    output logic [N-1:0] OutData,
    output logic [A-1:0] OutAddr,
    output logic         OutValid,
    input  logic         OutReady,
    output logic         Busy,
    output logic         Done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] SEND  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]   state;
    logic [A-1:0] last_addr;

    always_ff @(posedge Clk) begin
        if (R) begin
            state     <= IDLE;
            last_addr <= '0;
            RdAddr    <= '0;
            OutData   <= '0;
            OutAddr   <= '0;
            OutValid  <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    // Busy stays up through the Done cycle and drops on the
                    // first IDLE edge unless a new walk starts right there.
                    if (Start) begin
                        last_addr <= LastAddr;
                        RdAddr    <= FirstAddr;
                        Busy      <= 1'b1;
                        state     <= FETCH;
                    end else begin
                        Busy <= 1'b0;
                    end
                end
                FETCH: begin
                    OutData  <= RdData;
                    OutAddr  <= RdAddr;
                    OutValid <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (OutValid && OutReady) begin
                        OutValid <= 1'b0;
                        if (OutAddr == last_addr) begin
                            state <= DONE;
                        end else begin
                            RdAddr <= RdAddr + 1'b1;
                            state  <= FETCH;
                        end
                    end
                end
                DONE: begin
                    Done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_read_streamer.sv
// Directed bench for reg_file_read_streamer: a model register file feeds the
// DUT and a scoreboard queue holds the {addr, data} stream each walk must emit.
module tb_reg_file_read_streamer;

    localparam int N = 32;
    localparam int A = 5;

    typedef struct {
        logic [A-1:0] a;
        logic [N-1:0] d;
    } word_t;

    logic         Clk = 1'b0;
    logic         R = 1'b1;
    logic         Start = 1'b0;
    logic [A-1:0] FirstAddr = '0;
    logic [A-1:0] LastAddr = '0;
    logic [A-1:0] RdAddr;
    logic [N-1:0] RdData;
    logic [N-1:0] OutData;
    logic [A-1:0] OutAddr;
    logic         OutValid;
    logic         OutReady = 1'b1;
    logic         Busy;
    logic         Done;

    logic [N-1:0] rf [32];
    word_t        exp_q [$];
    int           hs_q [$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           last_hs = -100;
    int           word_cnt = 0;

    assign RdData = rf[RdAddr];

    always #5 Clk = ~Clk;

    reg_file_read_streamer #(.N(N), .A(A)) dut (
        .Clk(Clk), .R(R), .Start(Start), .FirstAddr(FirstAddr), .LastAddr(LastAddr),
        .RdAddr(RdAddr), .RdData(RdData), .OutData(OutData), .OutAddr(OutAddr),
        .OutValid(OutValid), .OutReady(OutReady), .Busy(Busy), .Done(Done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every accepted word is popped and compared.
    always @(posedge Clk) begin
        word_t w;
        cyc++;
        if (!R && OutValid && OutReady) begin
            last_hs = cyc;
            hs_q.push_back(cyc);
            word_cnt++;
            if (exp_q.size() == 0) begin
                chk("queue_nonempty", 64'(exp_q.size()), 64'd1);
            end else begin
                w = exp_q.pop_front();
                chk("word_addr", 64'(OutAddr), 64'(w.a));
                chk("word_data", 64'(OutData), 64'(w.d));
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_rdaddr"}, 64'(RdAddr), 64'd0);
        chk({tag, "_outdata"}, 64'(OutData), 64'd0);
        chk({tag, "_outaddr"}, 64'(OutAddr), 64'd0);
        chk({tag, "_outvalid"}, 64'(OutValid), 64'd0);
        chk({tag, "_busy"}, 64'(Busy), 64'd0);
        chk({tag, "_done"}, 64'(Done), 64'd0);
    endtask

    task automatic start_walk(input logic [A-1:0] f, input logic [A-1:0] l);
        logic [A-1:0] diff;
        logic [A-1:0] a;
        int n;
        diff = l - f;
        n = int'(diff) + 1;
        for (int i = 0; i < n; i++) begin
            a = f + A'(i);
            exp_q.push_back('{a: a, d: rf[a]});
        end
        word_cnt = 0;
        hs_q.delete();
        Start = 1'b1;
        FirstAddr = f;
        LastAddr = l;
        tick();
        Start = 1'b0;
        FirstAddr = f + 5'd7;
        LastAddr = f + 5'd2;
        chk("busy_after_start", 64'(Busy), 64'd1);
        chk("rdaddr_after_start", 64'(RdAddr), 64'(f));
        tick();
        chk("valid_after_fetch", 64'(OutValid), 64'd1);
    endtask

    task automatic wait_done(input int budget, input int words);
        for (int i = 0; i < budget; i++) begin
            if (Done) break;
            tick();
        end
        chk("done_seen", 64'(Done), 64'd1);
        if (Done) begin
            chk("done_after_last_hs", 64'(cyc - last_hs), 64'd1);
            chk("busy_in_done_cycle", 64'(Busy), 64'd1);
            tick();
            chk("done_one_cycle", 64'(Done), 64'd0);
            chk("busy_falls", 64'(Busy), 64'd0);
        end
        chk("word_count", 64'(word_cnt), 64'(words));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_word(input logic [A-1:0] a);
        for (int i = 0; i < 40; i++) begin
            if (OutValid && OutAddr == a) break;
            tick();
        end
        chk("reach_word", 64'(OutAddr), 64'(a));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
        rf[3] = 32'h11;
        rf[4] = 32'h22;
        rf[5] = 32'h33;
        rf[6] = 32'h44;

        // Reset held with Start pulsing
        R = 1'b1;
        tick();
        Start = 1'b1;
        FirstAddr = 5'd3;
        LastAddr = 5'd6;
        tick();
        tick();
        check_idle_zero("reset");
        Start = 1'b0;
        R = 1'b0;
        tick();
        check_idle_zero("idle");

        // Basic walk 3..6 with spacing check
        start_walk(5'd3, 5'd6);
        wait_done(40, 4);
        for (int i = 1; i < hs_q.size(); i++)
            chk("hs_spacing", 64'(hs_q[i] - hs_q[i-1]), 64'd2);

        // Backpressure at word 2
        start_walk(5'd3, 5'd6);
        wait_word(5'd4);
        OutReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 64'(OutValid), 64'd1);
            chk("bp_data", 64'(OutData), 64'h22);
            chk("bp_addr", 64'(OutAddr), 64'd4);
        end
        OutReady = 1'b1;
        wait_done(40, 4);

        // Wrap 30 -> 1
        start_walk(5'd30, 5'd1);
        wait_done(40, 4);

        // Single word
        start_walk(5'd9, 5'd9);
        wait_done(20, 1);

        // Full sweep, both ways of asking for it
        start_walk(5'd0, 5'd31);
        wait_done(200, 32);
        start_walk(5'd12, 5'd11);
        wait_done(200, 32);

        // Start mid-walk is ignored
        start_walk(5'd10, 5'd13);
        tick();
        Start = 1'b1;
        FirstAddr = 5'd20;
        LastAddr = 5'd25;
        tick();
        Start = 1'b0;
        wait_done(40, 4);
        tick();
        chk("no_queued_start", 64'(Busy), 64'd0);

        // Reset during SEND of word 2
        start_walk(5'd3, 5'd6);
        wait_word(5'd4);
        OutReady = 1'b0;
        R = 1'b1;
        tick();
        R = 1'b0;
        OutReady = 1'b1;
        check_idle_zero("midreset");
        exp_q.delete();
        tick();
        chk("midreset_no_done", 64'(Done), 64'd0);
        start_walk(5'd3, 5'd6);
        wait_done(40, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
